// File: rtl/arbiter_rr.sv
// arbiter_rr: AHB-Lite multi-master bus arbiter.
//
// Picks the address-phase owner each cycle by HIGH, LOW or round-robin
// priority. It supports locked transfers and burst holding, and an optional
// tenure limit. The data-phase owner is registered.
//
// Ports
//   HCLK            in   bus clock
//   HRESET          in   synchronous active-high reset
//   HTRANS          in   2*MM per-master transfer type, master i at [2i+1:2i]
//   HMASTLOCK       in   MM per-master lock request
//   HREADY          in   shared bus ready
//   ARB_SEL         out  MM one-hot address-phase grant (combinational)
//   MASTER_SEL      out  binary index of ARB_SEL
//   ARB_SEL_PREV    out  MM one-hot data-phase owner (registered)
//   MASTER_SEL_PREV out  binary data-phase owner (registered)
//   HANDOVER        out  pulse one cycle after MASTER_SEL_PREV changes
module arbiter_rr #(
  parameter int    MM             = 4,
  parameter string ARBITRATION    = "RR",
  parameter int    DEFAULT_MASTER = 0,
  parameter int    TENURE_MAX     = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic [2*MM-1:0]       HTRANS,
  input  logic [MM-1:0]         HMASTLOCK,
  input  logic                  HREADY,
  output logic [MM-1:0]         ARB_SEL,
  output logic [$clog2(MM)-1:0] MASTER_SEL,
  output logic [MM-1:0]         ARB_SEL_PREV,
  output logic [$clog2(MM)-1:0] MASTER_SEL_PREV,
  output logic                  HANDOVER
);

  localparam int MW = $clog2(MM);
  localparam int TW = (TENURE_MAX > 0) ? $clog2(TENURE_MAX + 1) : 1;
  localparam logic [MW-1:0] DEF_SEL = MW'(DEFAULT_MASTER);
  localparam logic [TW-1:0] TEN_SAT = (TENURE_MAX > 0) ? TW'(TENURE_MAX) : {TW{1'b1}};
  localparam logic [MM-1:0] ONE_HOT0 = {{(MM-1){1'b0}}, 1'b1};

  logic [MW-1:0] r_msel_prev;
  logic [MM-1:0] r_asel_prev;
  logic [MW-1:0] r_rr_ptr;
  logic [TW-1:0] r_tenure;
  logic          r_changed;
  logic          r_handover;

  logic [MM-1:0] w_req;
  logic [MM-1:0] w_others;
  logic [MM-1:0] w_elig;
  logic          w_owner_lock;
  logic          w_owner_cont;
  logic          w_hold;
  logic          w_limit;
  logic [MW-1:0] w_pick;
  logic [MW-1:0] w_sel;
  logic          w_fresh;

  // Request vector and the current owner's lock / continuation status.
  always_comb begin
    w_req        = '0;
    w_owner_lock = 1'b0;
    w_owner_cont = 1'b0;
    for (int i = 0; i < MM; i++) begin
      w_req[i] = HTRANS[2*i+1];
      if (r_msel_prev == MW'(i)) begin
        w_owner_lock = HMASTLOCK[i];
        w_owner_cont = HTRANS[2*i];  // BUSY or SEQ keeps the bus
      end
    end
  end

  assign w_hold   = w_owner_lock | w_owner_cont;
  assign w_others = w_req & ~r_asel_prev;
  // A master at its tenure limit steps aside only if someone else is waiting.
  assign w_limit  = (TENURE_MAX > 0) && (r_tenure == TW'(TENURE_MAX)) && (|w_others);
  assign w_elig   = w_limit ? w_others : w_req;

  always_comb begin
    int idx;
    w_pick = DEF_SEL;
    idx    = 0;
    if (ARBITRATION == "HIGH") begin
      for (int i = 0; i < MM; i++)
        if (w_elig[i]) w_pick = MW'(i);
    end else if (ARBITRATION == "LOW") begin
      for (int i = MM - 1; i >= 0; i--)
        if (w_elig[i]) w_pick = MW'(i);
    end else begin
      // Scan backwards so the requester closest to r_rr_ptr is written last.
      for (int k = MM - 1; k >= 0; k--) begin
        idx = int'(r_rr_ptr) + k;
        if (idx >= MM) idx = idx - MM;
        if (w_elig[idx]) w_pick = MW'(idx);
      end
    end
  end

  always_comb begin
    w_sel   = DEF_SEL;
    w_fresh = 1'b0;
    if (HRESET) begin
      w_sel = DEF_SEL;
    end else if (w_hold) begin
      w_sel = r_msel_prev;
    end else if (|w_req) begin
      w_sel   = w_pick;
      w_fresh = 1'b1;
    end
  end

  assign MASTER_SEL      = w_sel;
  assign ARB_SEL         = ONE_HOT0 << w_sel;
  assign MASTER_SEL_PREV = r_msel_prev;
  assign ARB_SEL_PREV    = r_asel_prev;
  assign HANDOVER        = r_handover;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_msel_prev <= DEF_SEL;
      r_asel_prev <= ONE_HOT0 << DEF_SEL;
      r_rr_ptr    <= '0;
      r_tenure    <= '0;
      r_changed   <= 1'b0;
      r_handover  <= 1'b0;
    end else begin
      // HANDOVER lags the owner change by one edge.
      r_handover <= r_changed;
      r_changed  <= 1'b0;
      if (HREADY) begin
        r_msel_prev <= w_sel;
        r_asel_prev <= ARB_SEL;
        r_changed   <= (w_sel != r_msel_prev);
        if (w_fresh) begin
          r_rr_ptr <= (w_sel == MW'(MM - 1)) ? '0 : w_sel + 1'b1;
          if (w_sel == r_msel_prev) begin
            if (r_tenure != TEN_SAT) r_tenure <= r_tenure + 1'b1;
          end else begin
            r_tenure <= TW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_arbiter_rr.sv
module tb_arbiter_rr;

  logic       HCLK;
  logic       HRESET;
  logic [7:0] HTRANS;
  logic [3:0] HMASTLOCK;
  logic       HREADY;

  logic [3:0] rr_asel, rr_aselp, hi_asel, hi_aselp, lo_asel, lo_aselp;
  logic [1:0] rr_msel, rr_mselp, hi_msel, hi_mselp, lo_msel, lo_mselp;
  logic       rr_ho, hi_ho, lo_ho;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  // transfer patterns: master i at [2i+1:2i], IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
  localparam logic [7:0] T_IDLE   = 8'b00000000;
  localparam logic [7:0] T_ALL_NS = 8'b10101010;

  arbiter_rr #(.MM(4), .ARBITRATION("RR"), .DEFAULT_MASTER(2), .TENURE_MAX(0)) u_rr (
    .HCLK(HCLK), .HRESET(HRESET), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HREADY(HREADY),
    .ARB_SEL(rr_asel), .MASTER_SEL(rr_msel), .ARB_SEL_PREV(rr_aselp),
    .MASTER_SEL_PREV(rr_mselp), .HANDOVER(rr_ho));

  arbiter_rr #(.MM(4), .ARBITRATION("HIGH"), .DEFAULT_MASTER(0), .TENURE_MAX(0)) u_high (
    .HCLK(HCLK), .HRESET(HRESET), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HREADY(HREADY),
    .ARB_SEL(hi_asel), .MASTER_SEL(hi_msel), .ARB_SEL_PREV(hi_aselp),
    .MASTER_SEL_PREV(hi_mselp), .HANDOVER(hi_ho));

  arbiter_rr #(.MM(4), .ARBITRATION("LOW"), .DEFAULT_MASTER(0), .TENURE_MAX(2)) u_low (
    .HCLK(HCLK), .HRESET(HRESET), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HREADY(HREADY),
    .ARB_SEL(lo_asel), .MASTER_SEL(lo_msel), .ARB_SEL_PREV(lo_aselp),
    .MASTER_SEL_PREV(lo_mselp), .HANDOVER(lo_ho));

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset();
    HRESET    = 1'b1;
    HTRANS    = T_IDLE;
    HMASTLOCK = 4'b0000;
    HREADY    = 1'b1;
    tick();
    tick();
    HRESET = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    HRESET = 1'b1; HTRANS = T_IDLE; HMASTLOCK = 4'b0000; HREADY = 1'b1;

    // ---- reset state, parking on default master ----
    tick(); tick();
    chk("rst_rr_mselp", 32'(rr_mselp), 32'd2);
    chk("rst_rr_aselp", 32'(rr_aselp), 32'b0100);
    chk("rst_rr_asel",  32'(rr_asel),  32'b0100);
    chk("rst_rr_ho",    32'(rr_ho),    32'd0);
    chk("rst_rr_ptr",   32'(u_rr.r_rr_ptr), 32'd0);
    chk("rst_hi_mselp", 32'(hi_mselp), 32'd0);
    chk("rst_hi_aselp", 32'(hi_aselp), 32'b0001);
    HRESET = 1'b0;
    #1;
    chk("idle_rr_asel", 32'(rr_asel), 32'b0100);
    tick();
    chk("idle_rr_mselp", 32'(rr_mselp), 32'd2);
    chk("idle_rr_ho",    32'(rr_ho),    32'd0);

    // ---- round robin, all masters NONSEQ ----
    HTRANS = T_ALL_NS;
    #1;
    chk("rr_sel0", 32'(rr_msel), 32'd0);
    chk("rr_onehot0", 32'(rr_asel), 32'b0001);
    tick();
    chk("rr_prev0", 32'(rr_mselp), 32'd0);
    chk("rr_ho0",   32'(rr_ho),    32'd0);
    chk("rr_ptr0",  32'(u_rr.r_rr_ptr), 32'd1);
    tick();
    chk("rr_prev1", 32'(rr_mselp), 32'd1);
    chk("rr_ho1",   32'(rr_ho),    32'd1);
    tick();
    chk("rr_prev2", 32'(rr_mselp), 32'd2);
    chk("rr_ho2",   32'(rr_ho),    32'd1);
    tick();
    chk("rr_prev3", 32'(rr_mselp), 32'd3);
    chk("rr_aselp3", 32'(rr_aselp), 32'b1000);
    chk("rr_ho3",   32'(rr_ho),    32'd1);
    tick();
    chk("rr_prev4", 32'(rr_mselp), 32'd0);
    chk("rr_ho4",   32'(rr_ho),    32'd1);
    chk("rr_ptr4",  32'(u_rr.r_rr_ptr), 32'd1);

    // ---- lock on master 2 with HREADY stalls ----
    do_reset();
    HTRANS = 8'b00100000;              // master 2 NONSEQ alone
    tick();
    chk("lk_prev_a", 32'(rr_mselp), 32'd2);
    chk("lk_ptr_a",  32'(u_rr.r_rr_ptr), 32'd3);
    HTRANS = 8'b00110010;              // master 2 SEQ, master 0 NONSEQ
    HMASTLOCK = 4'b0100;
    HREADY = 1'b0;
    #1;
    chk("lk_sel", 32'(rr_msel), 32'd2);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("lk_stall_prev", 32'(rr_mselp), 32'd2);
      chk("lk_stall_ptr",  32'(u_rr.r_rr_ptr), 32'd3);
      chk("lk_stall_ho",   32'(rr_ho), 32'd0);
    end
    HREADY = 1'b1;
    tick();
    chk("lk_held_ptr", 32'(u_rr.r_rr_ptr), 32'd3);
    // lock released and master 2 IDLE in the same cycle master 0 requests
    HTRANS = 8'b00000010;
    HMASTLOCK = 4'b0000;
    #1;
    chk("rel_sel", 32'(rr_msel), 32'd0);
    tick();
    chk("rel_prev", 32'(rr_mselp), 32'd0);
    chk("rel_ptr",  32'(u_rr.r_rr_ptr), 32'd1);
    chk("rel_ho_a", 32'(rr_ho), 32'd0);
    tick();
    chk("rel_ho_b", 32'(rr_ho), 32'd1);

    // ---- HIGH priority, master 1 burst while master 3 waits ----
    do_reset();
    HTRANS = 8'b00001000;              // master 1 NONSEQ alone
    #1;
    chk("hi_first_sel", 32'(hi_msel), 32'd1);
    tick();
    chk("hi_first_prev", 32'(hi_mselp), 32'd1);
    HTRANS = 8'b10001100;              // master 1 SEQ, master 3 NONSEQ
    for (int b = 0; b < 3; b++) begin
      #1;
      chk("hi_burst_sel", 32'(hi_msel), 32'd1);
      tick();
      chk("hi_burst_prev", 32'(hi_mselp), 32'd1);
    end
    HTRANS = 8'b10000000;              // master 1 IDLE
    #1;
    chk("hi_m3_sel", 32'(hi_msel), 32'd3);
    chk("hi_m3_asel", 32'(hi_asel), 32'b1000);
    tick();
    chk("hi_m3_prev", 32'(hi_mselp), 32'd3);
    chk("hi_m3_ho_a", 32'(hi_ho), 32'd0);
    tick();
    chk("hi_m3_ho_b", 32'(hi_ho), 32'd1);

    // ---- LOW with tenure limit 2, masters 0 and 3 NONSEQ ----
    do_reset();
    HTRANS = 8'b10000010;
    tick(); chk("ten_g1", 32'(lo_mselp), 32'd0);
    tick(); chk("ten_g2", 32'(lo_mselp), 32'd0);
    tick(); chk("ten_g3", 32'(lo_mselp), 32'd3);
    tick(); chk("ten_g4", 32'(lo_mselp), 32'd0);
    tick(); chk("ten_g5", 32'(lo_mselp), 32'd0);
    chk("ten_cnt5", 32'(u_low.r_tenure), 32'd2);
    tick(); chk("ten_g6", 32'(lo_mselp), 32'd3);
    chk("ten_cnt6", 32'(u_low.r_tenure), 32'd1);
    // master 0 alone: limit reached but still granted, counter saturates
    HTRANS = 8'b00000010;
    tick(); tick();
    chk("ten_cnt_lim", 32'(u_low.r_tenure), 32'd2);
    #1;
    chk("ten_only_sel", 32'(lo_msel), 32'd0);
    tick();
    chk("ten_only_prev", 32'(lo_mselp), 32'd0);
    chk("ten_sat", 32'(u_low.r_tenure), 32'd2);

    // ---- reset in the middle of a locked burst from master 1 ----
    do_reset();
    HTRANS = 8'b00001000;
    tick();
    chk("mb_prev", 32'(rr_mselp), 32'd1);
    chk("mb_ptr",  32'(u_rr.r_rr_ptr), 32'd2);
    HTRANS = 8'b00001100;
    HMASTLOCK = 4'b0010;
    HREADY = 1'b0;
    HRESET = 1'b1;
    tick();
    chk("mb_rst_prev",  32'(rr_mselp), 32'd2);
    chk("mb_rst_aselp", 32'(rr_aselp), 32'b0100);
    chk("mb_rst_ptr",   32'(u_rr.r_rr_ptr), 32'd0);
    chk("mb_rst_ho",    32'(rr_ho), 32'd0);
    HTRANS = T_IDLE;
    HMASTLOCK = 4'b0000;
    HREADY = 1'b1;
    #1;
    chk("mb_rst_asel", 32'(rr_asel), 32'b0100);
    HRESET = 1'b0;
    HTRANS = 8'b10001000;              // masters 1 and 3 NONSEQ
    #1;
    chk("mb_resume_sel", 32'(rr_msel), 32'd1);
    tick();
    chk("mb_resume_prev", 32'(rr_mselp), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/arbiter_rr.md
ARBITER_RR -- requirements
Module: arbiter_rr

Interface
REQ-001 SHALL have parameter MM, default 4, number of AHB-Lite masters; legal range 2..16.
REQ-002 SHALL have parameter ARBITRATION, default "RR", one of "HIGH" (highest index wins), "LOW" (lowest index wins), "RR" (round-robin).
REQ-003 SHALL have parameter DEFAULT_MASTER, default 0, master parked on when no master requests.
REQ-004 SHALL have parameter TENURE_MAX, default 0, maximum consecutive fresh grants to one master while others wait; 0 disables the limit.
REQ-005 SHALL have port HCLK  input  1  bus clock; all state updates on its rising edge.
REQ-006 SHALL have port HRESET  input  1  synchronous, active-high reset.
REQ-007 SHALL have port HTRANS  input  2*MM  per-master transfer type; master i at bits [2i+1:2i].
REQ-008 SHALL have port HMASTLOCK  input  MM  per-master lock request.
REQ-009 SHALL have port HREADY  input  1  shared bus ready; 1 completes the current data phase.
REQ-010 SHALL have port ARB_SEL  output  MM  one-hot address-phase grant (combinational).
REQ-011 SHALL have port MASTER_SEL  output  clog2(MM)  binary index of ARB_SEL.
REQ-012 SHALL have port ARB_SEL_PREV  output  MM  one-hot data-phase owner (registered).
REQ-013 SHALL have port MASTER_SEL_PREV  output  clog2(MM)  binary data-phase owner (registered).
REQ-014 SHALL have port HANDOVER  output  1  registered pulse, high one cycle after MASTER_SEL_PREV changes value.

Function
REQ-015 SHALL define req[i] = HTRANS[2i+1] (NONSEQ or SEQ); IDLE and BUSY are not requests.
REQ-016 SHALL hold the grant (MASTER_SEL = MASTER_SEL_PREV) when the owner has HMASTLOCK=1 or HTRANS of BUSY (01) or SEQ (11); tenure limit ignored while holding.
REQ-017 SHALL, when not holding and no req bit set, grant DEFAULT_MASTER.
REQ-018 SHALL, when not holding and req nonzero, select among eligible requesters: "HIGH" highest index, "LOW" lowest index, "RR" first requester scanning cyclically from rr_ptr upward.
REQ-019 SHALL keep ARB_SEL == 1 << MASTER_SEL at all times (exactly one bit set).
REQ-020 SHALL update MASTER_SEL_PREV/ARB_SEL_PREV to MASTER_SEL/ARB_SEL on a rising edge with HREADY=1; hold them when HREADY=0 (one-cycle address-to-data latency, stalls extend it).
REQ-021 SHALL hold rr_ptr (clog2(MM) bits, reset 0) and, on an HREADY=1 edge with a fresh (non-held) grant to requesting master g, load rr_ptr with (g+1) mod MM; wrap from MM-1 to 0.
REQ-022 SHALL hold rr_ptr on held grants, parked grants and HREADY=0 edges.
REQ-023 SHALL keep tenure counter (reset 0) counting consecutive fresh grants to the same master on HREADY=1 edges; reset to 1 on a fresh grant to a different master; unchanged on held or parked cycles or HREADY=0.
REQ-024 SHALL, when TENURE_MAX>0, counter == TENURE_MAX and another master requests, exclude MASTER_SEL_PREV from eligibility for that arbitration; if it is the only requester it is granted.
REQ-025 SHALL saturate the tenure counter at TENURE_MAX (no wrap).
REQ-026 SHALL register HANDOVER = 1 on the edge following any edge at which MASTER_SEL_PREV changed, else 0.
REQ-027 SHALL treat simultaneous lock release and new requests in one cycle as not holding (arbitration occurs that cycle).

Reset
REQ-028 SHALL, while HRESET=1 at a clock edge, load MASTER_SEL_PREV=DEFAULT_MASTER, ARB_SEL_PREV=1<<DEFAULT_MASTER, rr_ptr=0, tenure=0, HANDOVER=0, regardless of HREADY or a transfer in progress.
REQ-029 SHALL, during and after reset with all HTRANS IDLE, drive ARB_SEL=1<<DEFAULT_MASTER.
REQ-030 SHALL resume arbitration on the first edge after HRESET deasserts with no residual lock or burst state.

Verification
REQ-031 RR, MM=4, all masters NONSEQ continuously, HREADY=1 -> MASTER_SEL_PREV sequence 0,1,2,3,0; HANDOVER high every cycle after the first change.
REQ-032 HIGH, master 1 SEQ burst of 4 beats while master 3 requests -> master 1 kept all 4 beats, master 3 granted on the cycle master 1 returns IDLE/NONSEQ-free.
REQ-033 Master 2 HMASTLOCK=1 with HREADY=0 for 3 cycles -> MASTER_SEL_PREV stays 2, rr_ptr unchanged, HANDOVER 0.
REQ-034 LOW, TENURE_MAX=2, masters 0 and 3 NONSEQ continuously -> grants 0,0,3,0,0,3.
REQ-035 All IDLE with DEFAULT_MASTER=2 -> ARB_SEL=4'b0100; assert HRESET mid-burst of master 1 -> next edge MASTER_SEL_PREV=2, rr_ptr=0.
